// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   - FSM state encodings (ST_IDLE .. ST_STOP), 3 bits wide
//   - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD)
//   - parity_bit(): parity bit for a data word under a given mode
package uart_pkg;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] ST_IDLE   = 3'd0;
  localparam logic [StateW-1:0] ST_START  = 3'd1;
  localparam logic [StateW-1:0] ST_DATA   = 3'd2;
  localparam logic [StateW-1:0] ST_PARITY = 3'd3;
  localparam logic [StateW-1:0] ST_STOP   = 3'd4;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Even parity sends the XOR of the data bits so the total count of ones is even.
  function automatic logic parity_bit(input logic [7:0] word, input int unsigned mode);
    logic p;
    p = ^word;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time generator.
//   Counts 0..BAUD_DIV-1 and emits a one-cycle tick while the count sits at its
//   last value, so the consumer advances on the wrap edge.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   clr   in   restart the count from 0 on the next edge
//   tick  out  high during the final cycle of each bit time
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
//   Frames each accepted byte as start bit, 8 data bits LSB first, optional
//   parity bit and 1 or 2 stop bits. Words offered while busy are dropped.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   tx_data  in   [7:0] word to send, sampled on the accept edge
//   data_vld in   request from the producer
//   tx_rdy   out  registered; high when a word can be accepted
//   tx       out  registered serial line, idle high
//   busy     out  registered; inverse of tx_rdy
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       data_vld,
  output logic       tx_rdy,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD;
  localparam logic        HasParity = (PARITY != PAR_NONE);
  localparam logic        StopLast  = (STOP_BITS == 2);

  logic [StateW-1:0] state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic [2:0]        idx_next;
  logic              accept;
  logic              tick;

  // Handshake uses the registered ready, so a request in the last stop-bit
  // cycle is not taken.
  assign accept   = data_vld & rdy_q;
  assign idx_next = bit_idx_q + 3'd1;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    rdy_d      = rdy_q;

    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
        if (accept) begin
          state_d   = ST_START;
          data_d    = tx_data;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
          rdy_d     = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = data_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            if (HasParity) begin
              state_d = ST_PARITY;
              tx_d    = parity_bit(data_q, PARITY);
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = idx_next;
            tx_d      = data_q[idx_next];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == StopLast) begin
            state_d = ST_IDLE;
            rdy_d   = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase

    busy_d = ~rdy_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign tx     = tx_q;
  assign tx_rdy = rdy_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with BAUD_DIV = 16.
//   dut 0: no parity, 1 stop   dut 1: even, 1 stop
//   dut 2: odd, 1 stop         dut 3: odd, 2 stop
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] vld;
  logic [7:0] dat [4];
  logic [3:0] tx_w;
  logic [3:0] rdy_w;
  logic [3:0] busy_w;

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .data_vld(vld[0]),
    .tx_rdy(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
  );
  uart_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .data_vld(vld[1]),
    .tx_rdy(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
  );
  uart_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .data_vld(vld[2]),
    .tx_rdy(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2])
  );
  uart_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[3]), .data_vld(vld[3]),
    .tx_rdy(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse data_vld for one cycle; returns #1 after the accept edge.
  task automatic start_frame(input int d, input logic [7:0] w);
    @(posedge clk);
    #1;
    vld[d] = 1'b1;
    dat[d] = w;
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
  endtask

  // Called #1 after the accept edge. lev[i] is the expected line level of bit i.
  // Checks both ends of every bit and that ready stays low for exactly the frame.
  task automatic check_frame(input int d, input int nlev, input logic [11:0] lev,
                             input string tag);
    int f;
    f = nlev * 16;
    for (int c = 0; c < f; c++) begin
      if ((c % 16 == 0) || (c % 16 == 15)) begin
        check($sformatf("%s tx c%0d", tag, c), tx_w[d], lev[c/16]);
      end
      if ((c == 0) || (c == f - 1)) begin
        check($sformatf("%s rdy c%0d", tag, c), rdy_w[d], 0);
        check($sformatf("%s busy c%0d", tag, c), busy_w[d], 1);
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("%s end tx", tag), tx_w[d], 1);
    check($sformatf("%s end rdy", tag), rdy_w[d], 1);
    check($sformatf("%s end busy", tag), busy_w[d], 0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    vld     = '0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;

    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset tx%0d", i), tx_w[i], 1);
      check($sformatf("reset rdy%0d", i), rdy_w[i], 1);
      check($sformatf("reset busy%0d", i), busy_w[i], 0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Idle with no requests.
    bad = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) bad++;
    end
    check("idle bad cycles", bad, 0);

    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
    start_frame(0, 8'hA5);
    check_frame(0, 10, 12'b00_11_0100_1010, "a5 none");

    // 0x07: three ones -> even parity 1, odd parity 0.
    start_frame(1, 8'h07);
    check_frame(1, 11, 12'b0110_0000_1110, "07 even");
    start_frame(2, 8'h07);
    check_frame(2, 11, 12'b0100_0000_1110, "07 odd");
    start_frame(3, 8'h07);
    check_frame(3, 12, 12'b1100_0000_1110, "07 odd 2stop");

    // Back-to-back with data_vld held high; 0x33 offered mid-frame is dropped.
    @(posedge clk);
    #1;
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    @(posedge clk);
    #1;
    dat[0] = 8'hFF;
    fork
      check_frame(0, 10, 12'b0010_1010_1010, "55 b2b");
      begin
        repeat (80) @(posedge clk);
        #2;
        dat[0] = 8'h33;
        @(posedge clk);
        #2;
        dat[0] = 8'hFF;
      end
    join
    // Ready rose at the end of frame 1; the held request is taken on the next edge.
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    check_frame(0, 10, 12'b0011_1111_1110, "ff b2b");

    // Reset 70 cycles into a frame of zeros.
    start_frame(0, 8'h00);
    repeat (70) @(posedge clk);
    #2;
    check("pre-reset tx", tx_w[0], 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-frame reset tx", tx_w[0], 1);
    check("mid-frame reset rdy", rdy_w[0], 1);
    check("mid-frame reset busy", busy_w[0], 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) bad++;
    end
    check("post-reset idle bad cycles", bad, 0);

    start_frame(0, 8'hA5);
    check_frame(0, 10, 12'b00_11_0100_1010, "a5 after reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
